lly_coin_feeder: RTL and testbench
==================================

# lly_coin_feeder

Coin-sequence transmitter on the driving side of the `lly_VM` vending-machine coin interface. Operator coin requests enter a small FIFO, and the block replays them onto the machine's `D_in[1:0]` port as single-cycle, evenly spaced coin codes. It also watches the machine's `D_out` (dispense) and `D_C` (change) pulses and keeps running statistics. It sits between the board's button/switch front end and `lly_VM`, in the same clock domain.

## Interface
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2 and at least 2.
- `GAP`, default 2: idle cycles (`D_in` = 00) inserted after each driven coin; range 0–15.
- `CNT_W`, default 8: width of each statistics counter.
- `Clk`, in, 1: the only clock. All logic is rising-edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `coin_valid`, in, 1: a coin request is present.
- `coin_code`, in, 2: requested coin. 01 is a 0.5 coin; 10 is a 1.0 coin; 00 and 11 are illegal.
- `coin_ready`, out, 1: the FIFO can accept a request; equals !full.
- `clr_stats`, in, 1: synchronous clear of all three counters.
- `D_in`, out, 2: coin code to the vending machine. Registered.
- `D_out`, in, 1: dispense pulse from the vending machine.
- `D_C`, in, 1: change pulse from the vending machine.
- `busy`, out, 1: FIFO not empty or FSM not IDLE.
- `err_illegal`, out, 1: one-cycle pulse for a rejected coin code.
- `vend_cnt`, out, `CNT_W`: count of dispense events.
- `change_cnt`, out, `CNT_W`: count of change events.
- `paid_total`, out, `CNT_W`: total coins driven, in 0.5 units.

## Operation
- **Reset values:** `D_in` = 00, FIFO empty, `coin_ready` = 1, `busy` = 0, `err_illegal` = 0, all counters 0, FSM in IDLE, gap counter 0.
- **Push:**
  - On an edge where `coin_valid` & `coin_ready` and `coin_code` ∈ {01, 10}, the code is written to the FIFO.
  - On an edge where `coin_valid` & `coin_ready` and `coin_code` ∈ {00, 11}, nothing is written and `err_illegal` = 1 for the following cycle only.
- **Full FIFO:** `coin_ready` = 0, and requests are ignored with no error pulse. A pop in the same cycle does not raise `coin_ready` until the next cycle; there is no full-bypass.
- **Empty FIFO:** there is no bypass. A coin pushed at edge E0 is popped no earlier than edge E1.
- **FSM states:**
  - IDLE: if the FIFO is not empty, pop, set `D_in` = popped code, go to DRIVE. Otherwise hold `D_in` = 00.
  - DRIVE: lasts exactly 1 cycle. Then set `D_in` = 00 and load the gap counter with `GAP`.
    - If `GAP` = 0, behave as the GAP-exit case below.
    - Otherwise go to GAP.
  - GAP: decrement the counter each cycle. When it reaches 0, that is the GAP-exit edge:
    - if the FIFO is not empty, pop and go to DRIVE;
    - otherwise go to IDLE.
- **`paid_total`:** on each pop, add 1 for code 01 or 2 for code 10. Saturates at 2^`CNT_W`−1.
- **`vend_cnt` / `change_cnt`:** add 1 on each cycle where `D_out` / `D_C` is sampled high. Each saturates at 2^`CNT_W`−1. Both inputs are same-domain and are not synchronized.
- **`clr_stats`:** clear wins over any increment in the same cycle.
- **Reset mid-operation:** asserting `Reset` forces `D_in` = 00 and empties the FIFO asynchronously. Any coin in flight is dropped and not counted.

## Timing
- A push at edge E0 into an empty, IDLE block gives `D_in` = code from E1 to E2, then 00 from E2.
- Coin-to-coin spacing is exactly `GAP`+1 cycles while the FIFO stays non-empty.
- `D_in` is never non-00 for two consecutive cycles when `GAP` ≥ 1.
- `err_illegal` is high for the cycle after the rejecting edge.
- Counter updates are visible in the cycle after the sampled pulse.
- `busy` falls in the same cycle the FSM enters IDLE with an empty FIFO.

## Test plan
- **Single coin:** reset, then push 10 at E0 (`GAP` = 2). Expect `D_in` = 10 only during E1–E2, `paid_total` = 2, and `busy` = 0 from E4.
- **Flow control:** hold `coin_valid` = 1, `coin_code` = 01 for 12 cycles (`DEPTH` = 4, `GAP` = 2).
  - `coin_ready` must drop once the FIFO fills.
  - Every accepted coin appears on `D_in` exactly once, spaced 3 cycles apart.
  - Final `paid_total` equals the number of accepted handshakes.
- **Illegal codes:** push 11, then push 00. Expect two 1-cycle `err_illegal` pulses, `D_in` stays 00, the FIFO stays empty, and `paid_total` = 0.
- **Statistics and clear:**
  - Drive `D_out` high for 3 separate cycles and `D_C` high for 1 cycle. Expect `vend_cnt` = 3 and `change_cnt` = 1.
  - Then assert `clr_stats` in the same cycle as a `D_out` pulse. Expect both counters = 0.
- **Reset mid-DRIVE:** with 3 coins queued, assert `Reset` during DRIVE. Expect `D_in` = 00 immediately, and after release `busy` = 0 with no further coins driven.
- **Saturation:** with `CNT_W` = 4, apply 20 `D_out` pulses. Expect `vend_cnt` = 15.

Source files
------------

// File: rtl/lly_coin_feeder.sv
// rtl/lly_coin_feeder.sv - Coin request FIFO replayed onto lly_VM D_in with fixed spacing
// Also counts dispense/change pulses and the value of coins driven, all saturating.
module lly_coin_feeder #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             coin_valid,
  input  logic [1:0]       coin_code,
  output logic             coin_ready,
  input  logic             clr_stats,
  output logic [1:0]       D_in,
  input  logic             D_out,
  input  logic             D_C,
  output logic             busy,
  output logic             err_illegal,
  output logic [CNT_W-1:0] vend_cnt,
  output logic [CNT_W-1:0] change_cnt,
  output logic [CNT_W-1:0] paid_total
);
  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = DEPTH[AW:0];
  localparam logic [3:0]       GAP_LD   = GAP[3:0];
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;
  state_t state, state_nxt;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    gap_cnt, gap_nxt;
  logic [1:0]    d_in_nxt;
  logic [1:0]    pop_code;
  logic          empty, full, legal, push, reject, pop, gap_exit;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign coin_ready = !full;
  assign legal      = (coin_code == 2'b01) || (coin_code == 2'b10);
  assign push       = coin_valid && coin_ready && legal;
  assign reject     = coin_valid && coin_ready && !legal;
  assign pop_code   = mem[rd_ptr];
  assign busy       = !empty || (state != S_IDLE);

  // GAP = 0 skips the GAP state entirely: DRIVE exits straight away.
  assign gap_exit = ((state == S_DRIVE) && (GAP_LD == 4'd0)) ||
                    ((state == S_GAP) && (gap_cnt == 4'd1));

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    d_in_nxt  = 2'b00;
    pop       = 1'b0;
    unique case (state)
      S_IDLE:  ;
      S_DRIVE: begin
        gap_nxt   = GAP_LD;
        state_nxt = S_GAP;
      end
      S_GAP:   gap_nxt = gap_cnt - 4'd1;
      default: state_nxt = S_IDLE;
    endcase
    if ((state == S_IDLE) || gap_exit) begin
      if (!empty) begin
        pop       = 1'b1;
        d_in_nxt  = pop_code;
        state_nxt = S_DRIVE;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= coin_code;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      gap_cnt     <= 4'd0;
      D_in        <= 2'b00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
      vend_cnt    <= '0;
      change_cnt  <= '0;
      paid_total  <= '0;
    end else begin
      state       <= state_nxt;
      gap_cnt     <= gap_nxt;
      D_in        <= d_in_nxt;
      err_illegal <= reject;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (clr_stats) begin
        vend_cnt   <= '0;
        change_cnt <= '0;
        paid_total <= '0;
      end else begin
        vend_cnt   <= sat_add(vend_cnt, {1'b0, D_out});
        change_cnt <= sat_add(change_cnt, {1'b0, D_C});
        // Coin codes 01/10 are numerically the coin value in 0.5 units.
        paid_total <= sat_add(paid_total, pop ? pop_code : 2'b00);
      end
    end
  end
endmodule

// File: tb/tb_lly_coin_feeder.sv
// tb/tb_lly_coin_feeder.sv - Self-checking bench for lly_coin_feeder against a queue-based model
module tb_lly_coin_feeder;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int CNT_W = 4;
  localparam int MAX   = 15;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             coin_valid = 1'b0;
  logic [1:0]       coin_code = 2'b00;
  logic             clr_stats = 1'b0;
  logic             D_out = 1'b0;
  logic             D_C = 1'b0;
  logic             coin_ready, busy, err_illegal;
  logic [1:0]       D_in;
  logic [CNT_W-1:0] vend_cnt, change_cnt, paid_total;

  int checks = 0;
  int failures = 0;

  lly_coin_feeder #(.DEPTH(DEPTH), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_ready(coin_ready), .clr_stats(clr_stats), .D_in(D_in), .D_out(D_out),
    .D_C(D_C), .busy(busy), .err_illegal(err_illegal), .vend_cnt(vend_cnt),
    .change_cnt(change_cnt), .paid_total(paid_total)
  );

  always #5 Clk = ~Clk;

  // Model: pending coins with their push edge; a coin is driven at the first
  // edge after its push that is also GAP+1 edges after the previous coin.
  int         n = 0;
  int         last_drv = -100;
  logic [1:0] qc[$];
  int         qt[$];
  int         m_vend = 0, m_chg = 0, m_paid = 0;
  logic [1:0] m_din = 2'b00;
  logic       m_err = 1'b0, m_busy = 1'b0, m_ready = 1'b1;

  function automatic int sat(input int x);
    return (x > MAX) ? MAX : x;
  endfunction

  task automatic model_reset();
    qc.delete(); qt.delete();
    last_drv = -100;
    m_vend = 0; m_chg = 0; m_paid = 0;
    m_din = 2'b00; m_err = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
  endtask

  task automatic model_edge();
    bit rdy;
    int value, t;
    rdy = (qc.size() < DEPTH);
    value = 0;
    m_din = 2'b00;
    if (qc.size() > 0) begin
      t = (qt[0] + 1 > last_drv + GAP + 1) ? qt[0] + 1 : last_drv + GAP + 1;
      if (n >= t) begin
        m_din = qc[0];
        value = (qc[0] == 2'b01) ? 1 : 2;
        last_drv = n;
        void'(qc.pop_front());
        void'(qt.pop_front());
      end
    end
    m_err = coin_valid && rdy && (coin_code == 2'b00 || coin_code == 2'b11);
    if (coin_valid && rdy && (coin_code == 2'b01 || coin_code == 2'b10)) begin
      qc.push_back(coin_code);
      qt.push_back(n);
    end
    if (clr_stats) begin
      m_vend = 0; m_chg = 0; m_paid = 0;
    end else begin
      m_vend = sat(m_vend + int'(D_out));
      m_chg  = sat(m_chg + int'(D_C));
      m_paid = sat(m_paid + value);
    end
    m_busy  = (qc.size() > 0) || (n < last_drv + GAP + 1);
    m_ready = (qc.size() < DEPTH);
    n++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 1'b0; coin_code = 2'b00; clr_stats = 1'b0; D_out = 1'b0; D_C = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (D_in !== 2'b00) begin failures++; $display("FAIL reset_d_in got=%b exp=00", D_in); end
    checks++; if (coin_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", coin_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_illegal); end
    checks++; if ({vend_cnt, change_cnt, paid_total} !== '0) begin
      failures++; $display("FAIL reset_cnts got=%0d/%0d/%0d exp=0/0/0", vend_cnt, change_cnt, paid_total);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single_coin();
    do_reset();
    coin_valid = 1'b1; coin_code = 2'b10;
    tick();
    coin_valid = 1'b0; coin_code = 2'b00;
    checks++; if (D_in !== 2'b00) begin failures++; $display("FAIL single_e0_d_in got=%b exp=00", D_in); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (D_in !== ((k == 1) ? 2'b10 : 2'b00)) begin
        failures++; $display("FAIL single_d_in edge=%0d got=%b", k, D_in);
      end
      checks++; if (busy !== (k < 4)) begin
        failures++; $display("FAIL single_busy edge=%0d got=%b exp=%b", k, busy, (k < 4));
      end
    end
    checks++; if (paid_total !== 4'd2) begin failures++; $display("FAIL single_paid got=%0d exp=2", paid_total); end
  endtask

  task automatic test_flow_control();
    int acc, driven, prev;
    bit dropped;
    acc = 0; driven = 0; prev = -1; dropped = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      coin_valid = (c < 12); coin_code = 2'b01;
      checks++; if (coin_ready !== m_ready) begin
        failures++; $display("FAIL flow_ready cyc=%0d got=%b exp=%b", c, coin_ready, m_ready);
      end
      if (coin_valid && !coin_ready) dropped = 1;
      if (coin_valid && m_ready) acc++;
      tick();
      checks++; if (D_in !== m_din) begin
        failures++; $display("FAIL flow_d_in cyc=%0d got=%b exp=%b", c, D_in, m_din);
      end
      if (D_in != 2'b00) begin
        if (prev >= 0) begin
          checks++; if (c - prev != GAP + 1) begin
            failures++; $display("FAIL flow_spacing cyc=%0d got=%0d exp=%0d", c, c - prev, GAP + 1);
          end
        end
        prev = c;
        driven++;
      end
    end
    idle_inputs();
    checks++; if (dropped !== 1'b1) begin failures++; $display("FAIL flow_ready_drop got=%b exp=1", dropped); end
    checks++; if (driven != acc) begin failures++; $display("FAIL flow_driven got=%0d exp=%0d", driven, acc); end
    checks++; if (paid_total !== 4'(sat(acc))) begin
      failures++; $display("FAIL flow_paid got=%0d exp=%0d", paid_total, sat(acc));
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flow_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_illegal();
    do_reset();
    coin_valid = 1'b1; coin_code = 2'b11;
    tick();
    checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL illegal_11 got=%b exp=1", err_illegal); end
    coin_code = 2'b00;
    tick();
    checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL illegal_00 got=%b exp=1", err_illegal); end
    idle_inputs();
    tick();
    checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL illegal_drop got=%b exp=0", err_illegal); end
    for (int k = 0; k < 4; k++) begin
      checks++; if ({D_in, busy, paid_total} !== 7'd0) begin
        failures++; $display("FAIL illegal_idle k=%0d d_in=%b busy=%b paid=%0d exp=00/0/0", k, D_in, busy, paid_total);
      end
      tick();
    end
  endtask

  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      D_out = (k % 2 == 0);
      D_C   = (k == 1);
      tick();
    end
    idle_inputs();
    tick();
    checks++; if (vend_cnt !== 4'd3) begin failures++; $display("FAIL stats_vend got=%0d exp=3", vend_cnt); end
    checks++; if (change_cnt !== 4'd1) begin failures++; $display("FAIL stats_change got=%0d exp=1", change_cnt); end
    D_out = 1'b1; clr_stats = 1'b1;
    tick();
    idle_inputs();
    checks++; if ({vend_cnt, change_cnt} !== 8'd0) begin
      failures++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", vend_cnt, change_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      D_out = (k % 2 == 0);
      tick();
    end
    idle_inputs();
    checks++; if (vend_cnt !== 4'd15) begin failures++; $display("FAIL sat_vend got=%0d exp=15", vend_cnt); end
    checks++; if (vend_cnt !== 4'(m_vend)) begin failures++; $display("FAIL sat_model got=%0d exp=%0d", vend_cnt, m_vend); end
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      coin_valid = 1'b1; coin_code = 2'($urandom_range(1, 2));
      tick();
    end
    idle_inputs();
    checks++; if (D_in !== m_din) begin failures++; $display("FAIL rmd_pre_d_in got=%b exp=%b", D_in, m_din); end
    Reset = 1'b1;
    #1;
    checks++; if (D_in !== 2'b00) begin failures++; $display("FAIL rmd_async_d_in got=%b exp=00", D_in); end
    checks++; if (coin_ready !== 1'b1) begin failures++; $display("FAIL rmd_async_ready got=%b exp=1", coin_ready); end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++; if ({D_in, busy, paid_total} !== 7'd0) begin
        failures++; $display("FAIL rmd_after k=%0d d_in=%b busy=%b paid=%0d exp=00/0/0", k, D_in, busy, paid_total);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      coin_valid = ($urandom_range(0, 1) == 1);
      coin_code  = 2'($urandom_range(0, 3));
      D_out      = ($urandom_range(0, 3) == 0);
      D_C        = ($urandom_range(0, 5) == 0);
      clr_stats  = ($urandom_range(0, 63) == 0);
      tick();
      checks++; if (D_in !== m_din) begin failures++; $display("FAIL rnd_d_in cyc=%0d got=%b exp=%b", c, D_in, m_din); end
      checks++; if (coin_ready !== m_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, coin_ready, m_ready); end
      checks++; if (busy !== m_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, m_busy); end
      checks++; if (err_illegal !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err_illegal, m_err); end
      checks++; if (vend_cnt !== 4'(m_vend)) begin failures++; $display("FAIL rnd_vend cyc=%0d got=%0d exp=%0d", c, vend_cnt, m_vend); end
      checks++; if (change_cnt !== 4'(m_chg)) begin failures++; $display("FAIL rnd_change cyc=%0d got=%0d exp=%0d", c, change_cnt, m_chg); end
      checks++; if (paid_total !== 4'(m_paid)) begin failures++; $display("FAIL rnd_paid cyc=%0d got=%0d exp=%0d", c, paid_total, m_paid); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_coin();
    test_flow_control();
    test_illegal();
    test_stats();
    test_saturation();
    test_reset_mid_drive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
